display_scanner: RTL and testbench
==================================

# display_scanner

Time-multiplexed scan driver for the stopwatch's common-anode 4-digit display. It sits between the stopwatch BCD counter and `seven_segment_decoder`. Each refresh slot it selects one digit and drives that decoder's `state_i` and `current_digit_i` inputs, plus the active-low digit anodes. It provides a per-frame digit snapshot, an anti-ghosting guard interval and optional leading-zero blanking.

## Interface
- `NUM_DIGITS`, default 4: digits scanned; legal range 1..8.
- `REFRESH_DIV`, default 50000: clock cycles per digit slot; must be ≥ 2.
- `GUARD_CYCLES`, default 500: cycles at the start of each slot with all anodes off; must be < `REFRESH_DIV`.
- `clk_i` input, 1 bit: the single clock; all state changes on the rising edge.
- `reset_n_i` input, 1 bit: asynchronous, active-low reset.
- `enable_i` input, 1 bit: scan enable; low freezes the scan and darkens the display.
- `blank_lz_i` input, 1 bit: leading-zero blanking enable.
- `digits_i` input, 4×`NUM_DIGITS` bits: BCD/hex digits; bits [3:0] are digit 0 (least significant).
- `state_o` output, 3 bits: current digit index; connects to the decoder's `state_i`.
- `current_digit_o` output, 4 bits: snapshot value of the selected digit; connects to the decoder's `current_digit_i`.
- `anode_o` output, `NUM_DIGITS` bits: active-low anode enables, one-hot-low when lit.
- `frame_o` output, 1 bit: one-cycle pulse on the edge where the snapshot loads.

## Operation
- Prescaler `pcnt` counts 0..`REFRESH_DIV`-1 while `enable_i`=1, then wraps to 0. Wrap is the terminal count (TC).
- Digit index `idx` advances on TC and wraps from `NUM_DIGITS`-1 to 0. `state_o` = `idx`, zero-extended to 3 bits.
- Snapshot register loads `digits_i` on:
  - the TC edge where `idx` wraps to 0;
  - the first enabled edge after reset (`primed` flag clear; the load sets `primed`).
- `frame_o` pulses on every snapshot load.
- `current_digit_o` = snapshot digit[`idx`]. It is registered and updates on the same edge as `idx`.
- Blank condition for digit k:
  - `blank_lz_i`=1, snapshot digit k = 0, and every digit j>k = 0;
  - digit 0 is never blanked.
- `anode_o`:
  - all ones when `enable_i`=0, when `pcnt` < `GUARD_CYCLES`, or when the selected digit is blanked;
  - otherwise bit `idx` = 0 and all other bits = 1.
- `enable_i`=0 holds `pcnt`, `idx`, the snapshot and `primed`; `anode_o` goes all ones on the next edge.
- When `enable_i` returns high, counting resumes from the held `pcnt`.
- `digits_i` changes mid-frame have no visible effect until the next snapshot load (no tearing).
- The blank decision uses snapshot data only, never live `digits_i`.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Reset (asynchronous assert, synchronous deassert release):
  - `pcnt`=0, `idx`=0, snapshot=0, `primed`=0;
  - `state_o`=0, `current_digit_o`=0, `anode_o`=all ones, `frame_o`=0.
- First enabled edge after reset: snapshot loads and `frame_o`=1. `anode_o` stays all ones through `GUARD_CYCLES` cycles.
- Slot length is exactly `REFRESH_DIV` cycles; frame length is `NUM_DIGITS`×`REFRESH_DIV` cycles.
- On the TC edge, `idx`, `current_digit_o`, `state_o` and the guard (anodes off) all change together. The anode never lights with stale digit data.
- TC coinciding with the `enable_i` falling edge: the TC does not take effect. Gating is by `enable_i` sampled on that same edge.
- Reset asserted mid-slot: outputs go to reset values immediately, independent of the clock.
- `NUM_DIGITS`=1: `idx` is constantly 0 and the snapshot reloads every TC.

## Structure
- Package `display_pkg`:
  - `DIGIT_W`=4, `STATE_W`=3;
  - `typedef logic [DIGIT_W-1:0] digit_t`;
  - `ANODE_OFF` constant helper function.
- Sub-module `refresh_prescaler`:
  - parameter `DIV`;
  - ports: `clk_i`, `reset_n_i`, `enable_i`, `count_o`, `tc_o`;
  - instantiated once. The guard comparison uses `count_o`.
- The top holds the index/snapshot/primed registers, blank logic and output registers.

## Test plan
All scenarios use `NUM_DIGITS`=4, `REFRESH_DIV`=8, `GUARD_CYCLES`=2.
- **Reset/first frame:** release reset with `digits_i`=0x1234, `enable_i`=1.
  - `frame_o` pulses on cycle 1.
  - `anode_o`=1111 for 2 cycles, then 1110 with `current_digit_o`=4.
  - `state_o` then steps 0,1,2,3 every 8 cycles; digits shown 4,3,2,1; wraps at cycle 32.
- **Snapshot integrity:** change `digits_i` from 0x1234 to 0x9876 at `idx`=1.
  - The remaining slots still show 2,1.
  - The next frame, after the `frame_o` pulse, shows 6,7,8,9.
- **Leading-zero blanking:** `digits_i`=0x0050.
  - With `blank_lz_i`=1: digits 3 and 2 show `anode_o`=1111; digits 1 and 0 light (values 5, 0).
  - With `blank_lz_i`=0: all four digits light.
  - `digits_i`=0x0000 with `blank_lz_i`=1: only digit 0 lights.
- **Enable gating:** drop `enable_i` for 5 cycles at `pcnt`=4, `idx`=2.
  - `anode_o`=1111 next edge.
  - `idx` and `pcnt` hold; on resume the slot completes after 3 more cycles.
- **Asynchronous reset mid-slot:** assert `reset_n_i` between edges at `idx`=3.
  - Outputs are at reset values before the next edge.
  - After release, the first-frame behaviour repeats.

Source files
------------

// File: rtl/display_pkg.sv
// Shared widths, digit type and anode helpers for the display scan driver.
package display_pkg;
  localparam int DIGIT_W    = 4;
  localparam int STATE_W    = 3;
  localparam int MAX_DIGITS = 8;

  typedef logic [DIGIT_W-1:0] digit_t;

  // Active-low anodes: all ones means every digit is dark.
  function automatic logic [MAX_DIGITS-1:0] ANODE_OFF();
    return '1;
  endfunction
endpackage

// File: rtl/refresh_prescaler.sv
// Slot timer: counts 0..DIV-1 while enabled; tc_o marks the wrap edge.
module refresh_prescaler #(
  parameter int DIV = 50000
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    enable_i,
  output logic [$clog2(DIV)-1:0]  count_o,
  output logic                    tc_o
);
  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  assign tc_o = enable_i && (count_o == LAST);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_o <= '0;
    end else if (enable_i) begin
      count_o <= tc_o ? '0 : count_o + CW'(1);
    end
  end
endmodule

// File: rtl/display_scanner.sv
// Time-multiplexed scan driver for a common-anode multi-digit display with
// per-frame snapshot, guard interval and leading-zero blanking.
module display_scanner
  import display_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int GUARD_CYCLES = 500
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic                          enable_i,
  input  logic                          blank_lz_i,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] digits_i,
  output logic [STATE_W-1:0]            state_o,
  output digit_t                        current_digit_o,
  output logic [NUM_DIGITS-1:0]         anode_o,
  output logic                          frame_o
);
  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0]      GUARD    = CNT_W'(GUARD_CYCLES);
  localparam logic [STATE_W-1:0]    LAST_IDX = STATE_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] OFF      = NUM_DIGITS'(ANODE_OFF());

  logic [CNT_W-1:0]              pcnt, pcnt_next;
  logic                          tc;
  logic [STATE_W-1:0]            idx, idx_next;
  logic [DIGIT_W*NUM_DIGITS-1:0] snap, snap_next;
  logic                          primed, load;
  digit_t                        digit_next;
  logic                          blank_next;
  logic [NUM_DIGITS-1:0]         lit_next, anode_next;

  refresh_prescaler #(.DIV(REFRESH_DIV)) u_prescaler (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .enable_i  (enable_i),
    .count_o   (pcnt),
    .tc_o      (tc)
  );

  assign state_o = idx;

  // Everything is computed from post-edge values so that index, digit data
  // and the guard blanking all switch on the same TC edge.
  always_comb begin
    pcnt_next = tc ? '0 : pcnt + CNT_W'(1);
    idx_next  = idx;
    if (tc) idx_next = (idx == LAST_IDX) ? '0 : idx + STATE_W'(1);
    load      = !primed || (tc && (idx_next == '0));
    snap_next = load ? digits_i : snap;

    digit_next = '0;
    blank_next = blank_lz_i && (idx_next != '0);
    lit_next   = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_next == STATE_W'(k)) begin
        digit_next  = snap_next[k*DIGIT_W +: DIGIT_W];
        lit_next[k] = 1'b0;
      end
      if (STATE_W'(k) >= idx_next && snap_next[k*DIGIT_W +: DIGIT_W] != '0)
        blank_next = 1'b0;
    end

    anode_next = (pcnt_next < GUARD || blank_next) ? OFF : lit_next;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      idx             <= '0;
      snap            <= '0;
      primed          <= 1'b0;
      current_digit_o <= '0;
      anode_o         <= OFF;
      frame_o         <= 1'b0;
    end else if (enable_i) begin
      idx             <= idx_next;
      snap            <= snap_next;
      primed          <= 1'b1;
      current_digit_o <= digit_next;
      anode_o         <= anode_next;
      frame_o         <= load;
    end else begin
      anode_o         <= OFF;
      frame_o         <= 1'b0;
    end
  end
endmodule

// File: tb/tb_display_scanner.sv
// Scoreboard bench for display_scanner: lit/dark/frame events are matched
// against hand-computed expectations queued by the stimulus process.
module tb_display_scanner;
  localparam int EV_LIT   = 0;
  localparam int EV_DARK  = 1;
  localparam int EV_FRAME = 2;

  typedef struct {
    int         kind;
    int         cyc;
    logic [2:0] st;
    logic [3:0] dg;
    logic [3:0] an;
  } ev_t;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        enable_i;
  logic        blank_lz_i;
  logic [15:0] digits_i;
  logic [2:0]  state_o;
  logic [3:0]  current_digit_o;
  logic [3:0]  anode_o;
  logic        frame_o;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;
  int  cyc   = 0;

  display_scanner #(
    .NUM_DIGITS   (4),
    .REFRESH_DIV  (8),
    .GUARD_CYCLES (2)
  ) dut (
    .clk_i           (clk_i),
    .reset_n_i       (reset_n_i),
    .enable_i        (enable_i),
    .blank_lz_i      (blank_lz_i),
    .digits_i        (digits_i),
    .state_o         (state_o),
    .current_digit_o (current_digit_o),
    .anode_o         (anode_o),
    .frame_o         (frame_o)
  );

  initial forever #5 clk_i = ~clk_i;

  // Edges since the last reset release.
  always @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) cyc <= 0;
    else            cyc <= cyc + 1;
  end

  task automatic push_ev(input int kind, input int c, input logic [2:0] st,
                         input logic [3:0] dg, input logic [3:0] an);
    ev_t e;
    e.kind = kind; e.cyc = c; e.st = st; e.dg = dg; e.an = an;
    exp_q.push_back(e);
  endtask

  task automatic push_frame(input int c);
    push_ev(EV_FRAME, c, 3'd0, 4'd0, 4'b1111);
  endtask

  task automatic push_slot(input int c_lit, input int c_dark, input logic [2:0] st,
                           input logic [3:0] dg, input logic [3:0] an);
    push_ev(EV_LIT, c_lit, st, dg, an);
    push_ev(EV_DARK, c_dark, 3'd0, 4'd0, 4'b1111);
  endtask

  task automatic push_first_frame();
    push_frame(1);
    push_slot(2, 8, 3'd0, 4'd4, 4'b1110);
    push_slot(10, 16, 3'd1, 4'd3, 4'b1101);
    push_slot(18, 24, 3'd2, 4'd2, 4'b1011);
    push_slot(26, 32, 3'd3, 4'd1, 4'b0111);
    push_frame(32);
  endtask

  task automatic check(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (cyc %0d)", name, got, want, cyc);
    end
  endtask

  task automatic check_event(input int kind);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_event: kind %0d at cyc %0d st %0d dg %0d an %b",
               kind, cyc, state_o, current_digit_o, anode_o);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc ||
          (kind == EV_LIT && (state_o != e.st || current_digit_o != e.dg || anode_o != e.an))) begin
        n_err++;
        $display("FAIL event: got kind %0d cyc %0d st %0d dg %0d an %b, want kind %0d cyc %0d st %0d dg %0d an %b",
                 kind, cyc, state_o, current_digit_o, anode_o,
                 e.kind, e.cyc, e.st, e.dg, e.an);
      end
    end
  endtask

  // Monitor: reacts to the DUT lighting/darkening the display and to frame pulses.
  initial begin
    logic prev_lit, lit;
    prev_lit = 1'b0;
    forever begin
      @(negedge clk_i);
      if (!reset_n_i) begin
        prev_lit = 1'b0;
      end else begin
        lit = (anode_o != 4'b1111);
        if (lit != prev_lit) check_event(lit ? EV_LIT : EV_DARK);
        prev_lit = lit;
        if (frame_o) check_event(EV_FRAME);
      end
    end
  end

  task automatic wait_cyc(input int n);
    int g = 0;
    while (cyc < n && g < 2000) begin
      @(negedge clk_i);
      g++;
    end
    if (cyc != n) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_cyc: reached %0d, want %0d", cyc, n);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, int'(state_o), 0);
    check({tag, "_digit"}, int'(current_digit_o), 0);
    check({tag, "_anode"}, int'(anode_o), 4'b1111);
    check({tag, "_frame"}, int'(frame_o), 0);
  endtask

  initial begin
    reset_n_i  = 1'b0;
    enable_i   = 1'b1;
    blank_lz_i = 1'b0;
    digits_i   = 16'h1234;
    repeat (3) @(negedge clk_i);
    check_reset_outputs("reset");

    // First frame after reset.
    push_first_frame();
    reset_n_i = 1'b1;

    // Snapshot integrity: new digits mid-frame only show next frame.
    wait_cyc(12);
    check("mid_frame_state", int'(state_o), 1);
    digits_i = 16'h9876;
    push_slot(34, 40, 3'd0, 4'd6, 4'b1110);
    push_slot(42, 48, 3'd1, 4'd7, 4'b1101);
    push_slot(50, 56, 3'd2, 4'd8, 4'b1011);
    push_slot(58, 64, 3'd3, 4'd9, 4'b0111);
    push_frame(64);

    // Leading-zero blanking of 0x0050.
    wait_cyc(40);
    digits_i   = 16'h0050;
    blank_lz_i = 1'b1;
    push_slot(66, 72, 3'd0, 4'd0, 4'b1110);
    push_slot(74, 80, 3'd1, 4'd5, 4'b1101);
    push_frame(96);

    // Same data with blanking off: all four light.
    wait_cyc(96);
    blank_lz_i = 1'b0;
    push_slot(98, 104, 3'd0, 4'd0, 4'b1110);
    push_slot(106, 112, 3'd1, 4'd5, 4'b1101);
    push_slot(114, 120, 3'd2, 4'd0, 4'b1011);
    push_slot(122, 128, 3'd3, 4'd0, 4'b0111);
    push_frame(128);

    wait_cyc(100);
    digits_i = 16'h0000;

    // All-zero with blanking: only digit 0 lights.
    wait_cyc(128);
    blank_lz_i = 1'b1;
    push_slot(130, 136, 3'd0, 4'd0, 4'b1110);
    push_frame(160);

    // Live digits become non-zero, but blanking follows the snapshot.
    wait_cyc(131);
    digits_i = 16'h4321;
    push_slot(162, 168, 3'd0, 4'd1, 4'b1110);
    push_slot(170, 176, 3'd1, 4'd2, 4'b1101);
    push_slot(178, 181, 3'd2, 4'd3, 4'b1011);
    push_slot(186, 189, 3'd2, 4'd3, 4'b1011);
    push_slot(191, 197, 3'd3, 4'd4, 4'b0111);
    push_frame(197);

    // Enable gating at pcnt=4, idx=2 for five edges.
    wait_cyc(180);
    check("gate_state_before", int'(state_o), 2);
    enable_i = 1'b0;
    wait_cyc(183);
    check("gate_state_held", int'(state_o), 2);
    check("gate_anode_dark", int'(anode_o), 4'b1111);
    check("gate_digit_held", int'(current_digit_o), 3);
    wait_cyc(185);
    enable_i = 1'b1;
    push_slot(199, 205, 3'd0, 4'd1, 4'b1110);
    push_slot(207, 213, 3'd1, 4'd2, 4'b1101);
    push_slot(215, 221, 3'd2, 4'd3, 4'b1011);
    push_ev(EV_LIT, 223, 3'd3, 4'd4, 4'b0111);

    // Asynchronous reset between edges while digit 3 is lit.
    wait_cyc(225);
    check("pending_before_reset", exp_q.size(), 0);
    check("pre_reset_anode", int'(anode_o), 4'b0111);
    #2;
    reset_n_i = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    digits_i   = 16'h1234;
    blank_lz_i = 1'b0;
    repeat (2) @(negedge clk_i);
    push_first_frame();
    reset_n_i = 1'b1;

    wait_cyc(33);
    check("pending_at_end", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
